// File: rtl/ramp_pwm_gen.sv
// Triangle ramp engine with an integrated PWM output driven by the current level.
// Config is shadowed on an accepted start edge and is ignored for the rest of the run.
module ramp_pwm_gen #(
    parameter int LVL_W  = 4,
    parameter int STEP_W = 8,
    parameter int HOLD_W = 10,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] step_div,
    input  logic [LVL_W-1:0]  max_lvl,
    input  logic [HOLD_W-1:0] hold_hi,
    input  logic [HOLD_W-1:0] hold_lo,
    input  logic [CNT_W-1:0]  loop_cnt,
    output logic [LVL_W-1:0]  level,
    output logic              pwm,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase
);
    // state   | meaning
    // IDLE    | waiting for a start edge
    // UP      | level rises one step per tick
    // HOLD_HI | level held at peak
    // DOWN    | level falls one step per tick
    // HOLD_LO | level held at 0 between triangles
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [LVL_W-1:0]  level_q, level_n;
    logic [LVL_W-1:0]  pcnt, pcnt_n;
    logic [STEP_W-1:0] scnt, scnt_n;
    logic [HOLD_W-1:0] hcnt, hcnt_n;
    logic [CNT_W-1:0]  loops_left, loops_n;
    logic [STEP_W-1:0] step_s;
    logic [LVL_W-1:0]  max_s;
    logic [HOLD_W-1:0] hold_hi_s, hold_lo_s;
    logic [CNT_W-1:0]  loop_s;
    logic              start_r, pwm_q, done_q, done_n, pwm_n;
    logic              start_edge, accept, tick;
    logic [STEP_W-1:0] step_last;
    logic [HOLD_W-1:0] hold_hi_last, hold_lo_last;

    assign start_edge   = start & ~start_r;
    assign accept       = (state == IDLE) && start_edge && !abort;
    // Zero step/hold values behave as one clock
    assign step_last    = (step_s == '0) ? '0 : step_s - 1'b1;
    assign hold_hi_last = (hold_hi_s == '0) ? '0 : hold_hi_s - 1'b1;
    assign hold_lo_last = (hold_lo_s == '0) ? '0 : hold_lo_s - 1'b1;
    assign tick         = (scnt == step_last);

    always_comb begin
        state_n = state;
        level_n = level_q;
        scnt_n  = scnt;
        hcnt_n  = hcnt;
        loops_n = loops_left;
        done_n  = 1'b0;
        pcnt_n  = pcnt;
        if (state != IDLE)
            pcnt_n = (pcnt == max_s - 1'b1) ? '0 : pcnt + 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (max_lvl != '0) begin
                        state_n = UP;
                        level_n = '0;
                        scnt_n  = '0;
                        pcnt_n  = '0;
                        loops_n = loop_cnt;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            UP: begin
                scnt_n = tick ? '0 : scnt + 1'b1;
                if (tick) begin
                    if (level_q >= max_s - 1'b1) begin
                        level_n = max_s;
                        state_n = HOLD_HI;
                        hcnt_n  = hold_hi_last;
                    end else begin
                        level_n = level_q + 1'b1;
                    end
                end
            end
            HOLD_HI: begin
                if (hcnt == '0) begin
                    state_n = DOWN;
                    scnt_n  = '0;
                end else begin
                    hcnt_n = hcnt - 1'b1;
                end
            end
            DOWN: begin
                scnt_n = tick ? '0 : scnt + 1'b1;
                if (tick) begin
                    if (level_q <= 1) begin
                        level_n = '0;
                        if (loop_s == '0 || loops_left > 1) begin
                            if (loops_left != '0)
                                loops_n = loops_left - 1'b1;
                            state_n = HOLD_LO;
                            hcnt_n  = hold_lo_last;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        level_n = level_q - 1'b1;
                    end
                end
            end
            HOLD_LO: begin
                if (hcnt == '0) begin
                    state_n = UP;
                    scnt_n  = '0;
                end else begin
                    hcnt_n = hcnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort && state != IDLE) begin
            state_n = IDLE;
            level_n = '0;
            scnt_n  = '0;
            pcnt_n  = '0;
            done_n  = 1'b0;
        end

        // PWM is computed from next-cycle values so it lines up with level
        pwm_n = (state_n != IDLE) && (pcnt_n < level_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            level_q    <= '0;
            pcnt       <= '0;
            scnt       <= '0;
            hcnt       <= '0;
            loops_left <= '0;
            step_s     <= '0;
            max_s      <= '0;
            hold_hi_s  <= '0;
            hold_lo_s  <= '0;
            loop_s     <= '0;
            start_r    <= 1'b0;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            level_q    <= level_n;
            pcnt       <= pcnt_n;
            scnt       <= scnt_n;
            hcnt       <= hcnt_n;
            loops_left <= loops_n;
            start_r    <= start;
            pwm_q      <= pwm_n;
            done_q     <= done_n;
            if (accept) begin
                step_s    <= step_div;
                max_s     <= max_lvl;
                hold_hi_s <= hold_hi;
                hold_lo_s <= hold_lo;
                loop_s    <= loop_cnt;
            end
        end
    end

    assign level = level_q;
    assign pwm   = pwm_q;
    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign phase = state;
endmodule
